// File: rtl/fp_addsub_issue.sv
// Issue/capture stage around the combinational add_sub_top adder: launches operands, waits a settle window, registers the result.
// Optional sticky error flags are enabled with `define FP_ADDSUB_STICKY_FLAGS_EN.
module fp_addsub_issue #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             in_opcode,
    output logic             sign1,
    output logic             sign2,
    output logic [7:0]       exp1,
    output logic [7:0]       exp2,
    output logic [22:0]      sig1,
    output logic [22:0]      sig2,
    output logic             opcode,
    input  logic [31:0]      fp_out,
    input  logic [2:0]       err_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [2:0]       res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    input  logic             flags_clr,
    output logic [2:0]       flags
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          handshake;

    // HOLD forwards res_ready so a pop and the next push can share a cycle.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && res_ready);
    assign accept    = in_valid && in_ready;
    assign res_valid = (state == HOLD);
    assign handshake = res_valid && res_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            exp1     <= 8'd0;
            exp2     <= 8'd0;
            sig1     <= 23'd0;
            sig2     <= 23'd0;
            opcode   <= 1'b0;
            res_data <= 32'd0;
            res_err  <= 3'd0;
        end else begin
            if (accept) begin
                sign1  <= in_op1[31];
                exp1   <= in_op1[30:23];
                sig1   <= in_op1[22:0];
                sign2  <= in_op2[31];
                exp2   <= in_op2[30:23];
                sig2   <= in_op2[22:0];
                opcode <= in_opcode;
                cnt    <= CNT_LOAD;
            end
            case (state)
                IDLE: begin
                    if (in_valid) state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        res_data <= fp_out;
                        res_err  <= err_o;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) state <= in_valid ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (handshake) begin
            if (op_count != '1) op_count <= op_count + 1'b1;
            if ((res_err != 3'd0) && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'd0;
        end else if (flags_clr) begin
            flags <= handshake ? res_err : 3'd0;
        end else if (handshake) begin
            flags <= flags | res_err;
        end
    end
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign flags = 3'd0;
`endif

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Directed self-checking bench for fp_addsub_issue; the bench itself plays the role of add_sub_top.
// Expected flag values follow FP_ADDSUB_STICKY_FLAGS_EN.
module tb_fp_addsub_issue;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_op1;
    logic [31:0]      in_op2;
    logic             in_opcode;
    logic             sign1, sign2, opcode;
    logic [7:0]       exp1, exp2;
    logic [22:0]      sig1, sig2;
    logic [31:0]      fp_out;
    logic [2:0]       err_o;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [2:0]       res_err;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] err_count;
    logic             flags_clr;
    logic [2:0]       flags;

    int checks = 0;
    int passes = 0;

    fp_addsub_issue #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode),
        .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
        .sig1(sig1), .sig2(sig2), .opcode(opcode),
        .fp_out(fp_out), .err_o(err_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .busy(busy), .op_count(op_count), .err_count(err_count),
        .flags_clr(flags_clr), .flags(flags)
    );

    always #5 clk = ~clk;

    // Hand-computed adder results for the handful of operand sets the bench uses.
    function automatic logic [34:0] adderModel(input logic [31:0] a, input logic [31:0] b, input logic opc);
        if (a == 32'h3F800000 && b == 32'h40000000 && !opc) return {3'd0, 32'h40400000};
        if (a == 32'h40400000 && b == 32'h3F800000 &&  opc) return {3'd0, 32'h40000000};
        if (a == 32'h3F800000 && b == 32'h3F800000 && !opc) return {3'd0, 32'h40000000};
        if (a == 32'h40000000 && b == 32'h40000000 && !opc) return {3'd0, 32'h40800000};
        if (a == 32'h7F800000 && b == 32'hFF800000 && !opc) return {3'd1, 32'h7FC00000};
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !opc) return {3'd2, 32'h7F800000};
        return {3'd0, 32'hDEADBEEF};
    endfunction

    always_comb begin
        {err_o, fp_out} = adderModel({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);
    end

    function automatic logic [2:0] expFlags(input logic [2:0] v);
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        return v;
`else
        return 3'd0 & v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Drives a request and returns 1ns after the edge that accepted it; in_valid is left high.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic opc);
        logic ok;
        in_op1 = a; in_op2 = b; in_opcode = opc; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = in_ready;
            tick();
        end
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitResult(input string tag);
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        if (!res_valid) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] t5_a [5] = '{32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h40000000};
    logic [31:0] t5_b [5] = '{32'h40000000, 32'hFF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h40000000};
    logic [31:0] t5_r [5] = '{32'h40400000, 32'h7FC00000, 32'h40000000, 32'h7F800000, 32'h40800000};
    logic [2:0]  t5_e [5] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0};
    int          t5_oc[5] = '{1, 2, 3, 3, 3};
    int          t5_ec[5] = '{0, 1, 1, 2, 2};
    logic [2:0]  t5_f [5] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_opcode = 1'b0;
        res_ready = 1'b0; flags_clr = 1'b0;
        tick();
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        checkOutput("rst_op1_port", {sign1, exp1, sig1}, 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Test 1: 1.0 + 2.0, exact latency
        res_ready = 1'b1;
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        in_valid = 1'b0;
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t1_op1_port", {sign1, exp1, sig1}, 32'h3F800000);
        checkOutput("t1_op2_port", {sign2, exp2, sig2}, 32'h40000000);
        checkOutput("t1_opcode", 32'(opcode), 32'd0);
        tick();
        checkOutput("t1_valid_early", 32'(res_valid), 32'd0);
        tick();
        checkOutput("t1_valid", 32'(res_valid), 32'd1);
        checkOutput("t1_data", res_data, 32'h40400000);
        checkOutput("t1_err", 32'(res_err), 32'd0);
        tick();
        checkOutput("t1_op_count", 32'(op_count), 32'd1);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        // Test 2: 3.0 - 1.0 with downstream stalled
        res_ready = 1'b0;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
        in_op1 = 32'h3F800000; in_op2 = 32'h3F800000; in_opcode = 1'b0;
        waitResult("t2_result");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_data", res_data, 32'h40000000);
            checkOutput("t2_hold_valid", 32'(res_valid), 32'd1);
            checkOutput("t2_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t2_no_accept", {sign1, exp1, sig1}, 32'h40400000);
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        checkOutput("t2_op_count", 32'(op_count), 32'd2);
        checkOutput("t2_busy", 32'(busy), 32'd0);

        // Test 3: back-to-back requests
        doReset();
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        in_op1 = 32'h40000000; in_op2 = 32'h40000000; in_opcode = 1'b0;
        waitResult("t3_r0");
        checkOutput("t3_data0", res_data, 32'h40000000);
        tick();
        checkOutput("t3_no_bubble0", 32'(busy), 32'd1);
        checkOutput("t3_reaccept0", {sign1, exp1, sig1}, 32'h40000000);
        in_op1 = 32'h40400000; in_op2 = 32'h3F800000; in_opcode = 1'b1;
        waitResult("t3_r1");
        checkOutput("t3_data1", res_data, 32'h40800000);
        tick();
        checkOutput("t3_no_bubble1", 32'(busy), 32'd1);
        in_valid = 1'b0;
        waitResult("t3_r2");
        checkOutput("t3_data2", res_data, 32'h40000000);
        tick();
        checkOutput("t3_op_count", 32'(op_count), 32'd3);
        checkOutput("t3_idle", 32'(busy), 32'd0);

        // Test 4: asynchronous reset mid-SETTLE
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_res_data", res_data, 32'd0);
        checkOutput("t4_op_count", 32'(op_count), 32'd0);
        checkOutput("t4_op1_port", {sign1, exp1, sig1}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_no_valid", 32'(res_valid), 32'd0);
            tick();
        end
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        in_valid = 1'b0;
        waitResult("t4_r");
        checkOutput("t4_data", res_data, 32'h40400000);
        tick();
        checkOutput("t4_op_count_after", 32'(op_count), 32'd1);

        // Test 5: saturation and error accounting
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(t5_a[i], t5_b[i], 1'b0);
            in_valid = 1'b0;
            waitResult("t5_r");
            checkOutput("t5_data", res_data, t5_r[i]);
            checkOutput("t5_err", 32'(res_err), 32'(t5_e[i]));
            tick();
            checkOutput("t5_op_count", 32'(op_count), 32'(t5_oc[i]));
            checkOutput("t5_err_count", 32'(err_count), 32'(t5_ec[i]));
            checkOutput("t5_flags", 32'(flags), 32'(expFlags(t5_f[i])));
        end

        // Test 6: flags_clr coinciding with an error handshake, then alone
        applyStimulus(32'h7F800000, 32'hFF800000, 1'b0);
        in_valid = 1'b0;
        waitResult("t6_r");
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        checkOutput("t6_clr_with_hs", 32'(flags), 32'(expFlags(3'd1)));
        checkOutput("t6_err_count", 32'(err_count), 32'd3);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        checkOutput("t6_clr_alone", 32'(flags), 32'd0);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        in_valid = 1'b0;
        waitResult("t6_r2");
        tick();
        checkOutput("t6_flags_acc", 32'(flags), 32'(expFlags(3'd2)));
        checkOutput("t6_err_count_sat", 32'(err_count), 32'd3);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
